// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared definitions for the nonce feeder.
//   - feeder_state_t : feeder FSM states
//   - PAD_ONE_WORD   : SHA-256 '1' bit padding word that follows the nonce
//   - MSG_LEN_BITS   : total message length (80-byte header = 640 bits)
//   - build_tail_block(tail, nonce) : 512-bit padded second chunk
package bitcoin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD
    } feeder_state_t;

    localparam logic [31:0] PAD_ONE_WORD = 32'h8000_0000;
    localparam logic [31:0] MSG_LEN_BITS = 32'd640;

    // Nonce goes in exactly as given; any byte-order handling is upstream.
    function automatic logic [511:0] build_tail_block(input logic [95:0] tail,
                                                      input logic [31:0] nonce);
        return {tail, nonce, PAD_ONE_WORD, 320'b0, MSG_LEN_BITS};
    endfunction

endpackage

// File: rtl/bitcoin_nonce_feeder_if.sv
// bitcoin_nonce_feeder_if: job, hasher and result signals of the nonce feeder.
//   slave  : feeder side (takes jobs and digests, drives hasher inputs and results)
//   master : environment side (job source, hasher, result consumer)
// With NONCE_FEEDER_STATS_EN defined the bundle also carries hash_count.
interface bitcoin_nonce_feeder_if;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_midstate;
    logic [95:0]  job_tail;
    logic [255:0] job_target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         sha_en;
    logic [511:0] sha_padding;
    logic [255:0] sha_midstate;
    logic [255:0] hash_value;
    logic         found_valid;
    logic [31:0]  found_nonce;
    logic         found_ready;
    logic         done;
`ifdef NONCE_FEEDER_STATS_EN
    logic [63:0]  hash_count;
`endif

    modport slave (
        input  job_valid, job_midstate, job_tail, job_target, nonce_start, nonce_end,
        input  hash_value, found_ready,
        output job_ready, sha_en, sha_padding, sha_midstate, found_valid, found_nonce, done
`ifdef NONCE_FEEDER_STATS_EN
        , output hash_count
`endif
    );

    modport master (
        output job_valid, job_midstate, job_tail, job_target, nonce_start, nonce_end,
        output hash_value, found_ready,
        input  job_ready, sha_en, sha_padding, sha_midstate, found_valid, found_nonce, done
`ifdef NONCE_FEEDER_STATS_EN
        , input hash_count
`endif
    );
endinterface

// File: rtl/bitcoin_nonce_feeder_valid_delay_line.sv
// valid_delay_line: DEPTH-deep valid shift register tracking hasher latency.
//   in_vld   : a request enters the hasher this cycle
//   out_vld  : the request issued DEPTH cycles ago has its result valid now
//   inflight : requests issued but whose result has not yet been presented
module valid_delay_line #(
    parameter int DEPTH = 66,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             out_vld,
    output logic [CNT_W-1:0] inflight
);
    logic [DEPTH-1:0] vld_pipe;

    assign out_vld = vld_pipe[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            inflight <= '0;
        end else begin
            // Shift form works for DEPTH == 1 as well.
            vld_pipe <= (vld_pipe << 1) | DEPTH'(in_vld);
            inflight <= inflight + CNT_W'(in_vld) - CNT_W'(out_vld);
        end
    end
endmodule

// File: rtl/bitcoin_nonce_feeder.sv
// bitcoin_nonce_feeder: streams padded header tails (one nonce per cycle) into
// the SHA-256 second-chunk hasher and reports the first digest below target.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : job handshake, hasher drive (sha_*), hasher digest, result
//                handshake (found_*), end-of-job done pulse
// Parameter HASH_LATENCY: cycles from sha_en to the matching hash_value.
// Optional: NONCE_FEEDER_STATS_EN adds a saturating 64-bit hash_count.
module bitcoin_nonce_feeder
    import bitcoin_pkg::*;
#(
    parameter int HASH_LATENCY = 66
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bitcoin_nonce_feeder_if.slave   bus
);
    localparam int CNT_W = $clog2(HASH_LATENCY + 2);

    feeder_state_t state, nxt;

    logic [255:0] midstate_r, target_r;
    logic [95:0]  tail_r;
    logic [31:0]  end_r, issue_nonce, res_nonce, found_nonce_r;
    logic         found_valid_r, hit_seen;
    logic         res_vld, hit, job_ready, sha_en, done;
    logic [CNT_W-1:0] inflight;

    valid_delay_line #(.DEPTH(HASH_LATENCY), .CNT_W(CNT_W)) u_vdl (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (sha_en),
        .out_vld  (res_vld),
        .inflight (inflight)
    );

    // Only the first hit of a job counts; later hits (drain tail) are dropped.
    assign hit = res_vld && !hit_seen && (bus.hash_value < target_r);

    always_comb begin
        nxt       = state;
        job_ready = 1'b0;
        sha_en    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (bus.job_valid) nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                sha_en = 1'b1;
                if (issue_nonce == end_r || hit) nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Going through HOLD even if the result was already taken
                // keeps done one cycle after the later of drain end / handshake.
                if (inflight == '0) begin
                    if (hit_seen) begin
                        nxt = ST_HOLD;
                    end else begin
                        done = 1'b1;
                        nxt  = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!found_valid_r) begin
                    done = 1'b1;
                    nxt  = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            midstate_r    <= '0;
            target_r      <= '0;
            tail_r        <= '0;
            end_r         <= '0;
            issue_nonce   <= '0;
            res_nonce     <= '0;
            found_nonce_r <= '0;
            found_valid_r <= 1'b0;
            hit_seen      <= 1'b0;
        end else begin
            state <= nxt;
            if (job_ready && bus.job_valid) begin
                midstate_r  <= bus.job_midstate;
                target_r    <= bus.job_target;
                tail_r      <= bus.job_tail;
                end_r       <= bus.nonce_end;
                issue_nonce <= bus.nonce_start;
                res_nonce   <= bus.nonce_start;
                hit_seen    <= 1'b0;
            end else begin
                if (sha_en)  issue_nonce <= issue_nonce + 32'd1;
                if (res_vld) res_nonce   <= res_nonce + 32'd1;
                if (hit)     hit_seen    <= 1'b1;
            end
            if (hit) begin
                found_valid_r <= 1'b1;
                found_nonce_r <= res_nonce;
            end else if (found_valid_r && bus.found_ready) begin
                found_valid_r <= 1'b0;
            end
        end
    end

`ifdef NONCE_FEEDER_STATS_EN
    logic [63:0] hash_count_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              hash_count_r <= '0;
        else if (res_vld && hash_count_r != '1)  hash_count_r <= hash_count_r + 64'd1;
    end
    assign bus.hash_count = hash_count_r;
`endif

    assign bus.job_ready    = job_ready;
    assign bus.sha_en       = sha_en;
    assign bus.sha_padding  = sha_en ? build_tail_block(tail_r, issue_nonce) : '0;
    assign bus.sha_midstate = midstate_r;
    assign bus.found_valid  = found_valid_r;
    assign bus.found_nonce  = found_nonce_r;
    assign bus.done         = done;
endmodule

// File: tb/tb_bitcoin_nonce_feeder.sv
// Testbench for bitcoin_nonce_feeder: table of directed jobs against a stub
// hasher of fixed latency, plus hand-written backpressure and reset sequences.
module tb_bitcoin_nonce_feeder;
    localparam int L = 5;
    localparam logic [255:0] TOP   = {1'b1, 255'b0};
    localparam logic [255:0] BELOW = {1'b0, {255{1'b1}}};

    typedef struct {
        logic [31:0]  start;
        logic [31:0]  stop;
        logic         hit_en;
        logic [31:0]  hit_a;
        logic [31:0]  hit_b;
        logic [255:0] hit_val;
        logic [255:0] target;
        int           exp_n;
        logic         exp_found;
        logic [31:0]  exp_nonce;
        int           exp_rise;
        int           exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   total_hashes = 0;

    logic         hit_en = 1'b0;
    logic [31:0]  hit_a = '0, hit_b = '0;
    logic [255:0] hit_val = '0;
    logic [31:0]  npipe [L];

    vec_t tbl [8];

    bitcoin_nonce_feeder_if bus();
    bitcoin_nonce_feeder #(.HASH_LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub hasher: digest depends only on the nonce, valid L cycles after issue.
    always @(posedge clk) begin
        npipe[0] <= bus.sha_padding[415:384];
        for (int i = 1; i < L; i++) npipe[i] <= npipe[i-1];
    end
    always_comb begin
        bus.hash_value = '1;
        if (hit_en && (npipe[L-1] == hit_a || npipe[L-1] == hit_b)) bus.hash_value = hit_val;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [95:0]  tail;
        logic [255:0] mid;
        logic [31:0]  fn;
        logic         seen;
        int           n, rise, dn, bad, t0;
        tail = {32'hdeadbeef, 32'h5f000000 + 32'(idx), 32'h17030a2b};
        mid  = {8{32'h01234567 + 32'(idx)}};
        hit_en = v.hit_en; hit_a = v.hit_a; hit_b = v.hit_b; hit_val = v.hit_val;
        @(negedge clk);
        chk($sformatf("v%0d job_ready", idx), bus.job_ready, 1);
        bus.job_valid = 1'b1; bus.job_midstate = mid; bus.job_tail = tail;
        bus.job_target = v.target; bus.nonce_start = v.start; bus.nonce_end = v.stop;
        t0 = cyc;
        @(negedge clk);
        bus.job_valid = 1'b0;
        n = 0; rise = -1; dn = -1; bad = 0; seen = 1'b0; fn = '0;
        while (dn < 0 && cyc - t0 < 200) begin
            if (bus.sha_en) begin
                if (bus.sha_padding !== {tail, v.start + 32'(n), 32'h80000000, 320'b0, 32'h00000280} ||
                    bus.sha_midstate !== mid) bad++;
                n++;
            end
            if (bus.found_valid && !seen) begin
                seen = 1'b1; rise = cyc - t0; fn = bus.found_nonce;
            end
            if (bus.done) dn = cyc - t0;
            @(negedge clk);
        end
        total_hashes += n;
        chk($sformatf("v%0d done_seen", idx), dn >= 0, 1);
        chk($sformatf("v%0d issued", idx), n, v.exp_n);
        chk($sformatf("v%0d block_bad", idx), bad, 0);
        chk($sformatf("v%0d found", idx), seen, v.exp_found);
        chk($sformatf("v%0d done_cyc", idx), dn, v.exp_done);
        if (v.exp_found) begin
            chk($sformatf("v%0d found_nonce", idx), fn, v.exp_nonce);
            chk($sformatf("v%0d found_rise", idx), rise, v.exp_rise);
        end
    endtask

    initial begin
        int   t0, held, quiet;
        logic got;
        // start, stop, hit_en, hit_a, hit_b, hit_val, target, n, found, nonce, rise, done
        tbl[0] = '{32'h10,       32'h13, 1'b0, 32'h0,  32'h0,  256'h0,    TOP,       4, 1'b0, 32'h0,  -1, 10};
        tbl[1] = '{32'h10,       32'h1f, 1'b1, 32'h12, 32'h12, 256'h0,    256'h1,    8, 1'b1, 32'h12,  9, 15};
        tbl[2] = '{32'hfffffffe, 32'h1,  1'b0, 32'h0,  32'h0,  256'h0,    TOP,       4, 1'b0, 32'h0,  -1, 10};
        tbl[3] = '{32'h5,        32'h5,  1'b1, 32'h5,  32'h5,  256'h1000, 256'h1000, 1, 1'b0, 32'h0,  -1,  7};
        tbl[4] = '{32'h20,       32'h2f, 1'b1, 32'h21, 32'h22, 256'h0,    256'h1,    7, 1'b1, 32'h21,  8, 14};
        tbl[5] = '{32'h30,       32'h33, 1'b1, 32'h33, 32'h33, 256'h0,    256'h1,    4, 1'b1, 32'h33, 10, 11};
        tbl[6] = '{32'h40,       32'h40, 1'b1, 32'h40, 32'h40, 256'hfff,  256'h1000, 1, 1'b1, 32'h40,  7,  8};
        tbl[7] = '{32'h50,       32'h5f, 1'b1, 32'h50, 32'h50, BELOW,     TOP,       6, 1'b1, 32'h50,  7, 13};

        bus.job_valid = 1'b0; bus.job_midstate = '0; bus.job_tail = '0; bus.job_target = '0;
        bus.nonce_start = '0; bus.nonce_end = '0; bus.found_ready = 1'b1;

        @(negedge clk);
        chk("rst job_ready", bus.job_ready, 1);
        chk("rst sha_en", bus.sha_en, 0);
        chk("rst sha_padding", bus.sha_padding[255:0] | bus.sha_padding[511:256], 0);
        chk("rst sha_midstate", bus.sha_midstate, 0);
        chk("rst found_valid", bus.found_valid, 0);
        chk("rst found_nonce", bus.found_nonce, 0);
        chk("rst done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Backpressure: result held for 10 cycles, done one cycle after handshake.
        hit_en = 1'b1; hit_a = 32'h12; hit_b = 32'h12; hit_val = '0;
        bus.found_ready = 1'b0;
        @(negedge clk);
        bus.job_valid = 1'b1; bus.job_target = 256'h1;
        bus.nonce_start = 32'h10; bus.nonce_end = 32'h1f;
        t0 = cyc;
        @(negedge clk);
        bus.job_valid = 1'b0;
        got = 1'b0;
        while (!got && cyc - t0 < 100) begin
            if (bus.found_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("hold found_seen", got, 1);
        chk("hold found_nonce", bus.found_nonce, 32'h12);
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.found_valid && !bus.done) held++;
        end
        chk("hold kept", held, 10);
        bus.found_ready = 1'b1;
        @(negedge clk);
        chk("hold valid_clear", bus.found_valid, 0);
        chk("hold done", bus.done, 1);
        @(negedge clk);
        chk("hold idle", bus.job_ready, 1);
        total_hashes += 8;

`ifdef NONCE_FEEDER_STATS_EN
        chk("hash_count", bus.hash_count, 64'(total_hashes));
`endif

        // Reset in the middle of issuing.
        hit_en = 1'b0;
        bus.job_valid = 1'b1; bus.job_target = TOP;
        bus.nonce_start = 32'h100; bus.nonce_end = 32'h1ff;
        @(negedge clk);
        bus.nonce_start = 32'h900;
        repeat (2) @(negedge clk);
        chk("busy sha_en", bus.sha_en, 1);
        chk("busy job_ready", bus.job_ready, 0);
        bus.job_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid rst job_ready", bus.job_ready, 1);
        chk("mid rst sha_en", bus.sha_en, 0);
        chk("mid rst sha_padding", bus.sha_padding[255:0] | bus.sha_padding[511:256], 0);
        chk("mid rst sha_midstate", bus.sha_midstate, 0);
        chk("mid rst found_nonce", bus.found_nonce, 0);
        chk("mid rst done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (L + 4) begin
            @(negedge clk);
            if (!bus.sha_en && !bus.found_valid && !bus.done && bus.job_ready) quiet++;
        end
        chk("post rst quiet", quiet, L + 4);
`ifdef NONCE_FEEDER_STATS_EN
        chk("post rst hash_count", bus.hash_count, 0);
`endif
        run_vec(8, tbl[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
